// File: rtl/scm_sched_pkg.sv
// Shared types and constants for the single-row write scheduler and its arbiter.
package scm_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSample,
        StCommit
    } sched_state_e;

    // Wide enough for up to 16 requesters.
    localparam int unsigned RR_PTR_W = 4;

    function automatic logic [RR_PTR_W-1:0] onehot_to_idx(input logic [15:0] oh);
        logic [RR_PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                idx = idx | RR_PTR_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/scm_rr_arbiter.sv
// Round-robin arbiter: the search starts one past ptr_i (mod N); one-hot grant out.
module scm_rr_arbiter
    import scm_sched_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]        req_i,
    input  logic [RR_PTR_W-1:0] ptr_i,
    output logic [N-1:0]        gnt_o
);

    localparam logic [RR_PTR_W-1:0] LastIdx = RR_PTR_W'(N - 1);

    logic [RR_PTR_W-1:0] start;
    logic [N-1:0]        req_rot;
    logic [N-1:0]        sel_rot;

    // Rotate so the start index is bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        start   = (ptr_i >= LastIdx) ? '0 : ptr_i + 1'b1;
        req_rot = N'({req_i, req_i} >> start);
        sel_rot = req_rot & (~req_rot + {{(N-1){1'b0}}, 1'b1});
        gnt_o   = N'(({sel_rot, sel_rot} << start) >> N);
    end

endmodule

// File: rtl/scm_1row_write_scheduler.sv
// Schedules writes from several requesters into one SCM row (IDLE -> SAMPLE -> COMMIT).
// Define SCM_WSCHED_PRIO0_EN to give requester 0 absolute priority over the round-robin.
module scm_1row_write_scheduler
    import scm_sched_pkg::*;
#(
    parameter int unsigned N_WREQ     = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_READ     = 2,
    parameter int unsigned VER_WIDTH  = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_WREQ-1:0]                  wreq_valid_i,
    input  logic [N_WREQ-1:0][DATA_WIDTH-1:0]  wreq_data_i,
    output logic [N_WREQ-1:0]                  wreq_ready_o,
    input  logic [N_READ-1:0]                  rd_lock_i,
    output logic                               WriteEnable_o,
    output logic [DATA_WIDTH-1:0]              WriteData_o,
    output logic                               row_valid_o,
    output logic [VER_WIDTH-1:0]               row_version_o,
    output logic                               busy_o
);

    sched_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [RR_PTR_W-1:0]   last_q, last_d;
    logic                  valid_q, valid_d;
    logic [VER_WIDTH-1:0]  ver_q, ver_d;

    logic [N_WREQ-1:0]     arb_req;
    logic [N_WREQ-1:0]     arb_gnt;
    logic [N_WREQ-1:0]     gnt;
    logic [DATA_WIDTH-1:0] sel_data;

`ifdef SCM_WSCHED_PRIO0_EN
    assign arb_req = wreq_valid_i & ~N_WREQ'(1);
    assign gnt     = wreq_valid_i[0] ? N_WREQ'(1) : arb_gnt;
`else
    assign arb_req = wreq_valid_i;
    assign gnt     = arb_gnt;
`endif

    scm_rr_arbiter #(
        .N (N_WREQ)
    ) u_arb (
        .req_i (arb_req),
        .ptr_i (last_q),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        last_d       = last_q;
        valid_d      = valid_q;
        ver_d        = ver_q;
        wreq_ready_o = '0;
        sel_data     = '0;
        for (int i = 0; i < N_WREQ; i++) begin
            if (gnt[i]) begin
                sel_data = sel_data | wreq_data_i[i];
            end
        end
        unique case (state_q)
            StIdle: begin
                // Grant is combinational, so it is also masked while reset is held.
                if (rst_n && (rd_lock_i == '0) && (gnt != '0)) begin
                    wreq_ready_o = gnt;
                    data_d       = sel_data;
                    last_d       = onehot_to_idx(16'(gnt));
                    state_d      = StSample;
                end
            end
            StSample: state_d = StCommit;
            StCommit: begin
                state_d = StIdle;
                valid_d = 1'b1;
                ver_d   = ver_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            last_q  <= RR_PTR_W'(N_WREQ - 1);
            valid_q <= 1'b0;
            ver_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            ver_q   <= ver_d;
        end
    end

    assign WriteEnable_o = (state_q != StIdle);
    assign busy_o        = (state_q != StIdle);
    assign WriteData_o   = data_q;
    assign row_valid_o   = valid_q;
    assign row_version_o = ver_q;

endmodule
